// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer: FSM state encoding and width.
package timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: counts 0..reload while enabled and flags the reload cycle.
module tick_prescaler #(
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      en,
    input  logic [PRESCALE_WIDTH-1:0] reload,
    output logic                      enable
);

    localparam logic [PRESCALE_WIDTH-1:0] PSC_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    logic [PRESCALE_WIDTH-1:0] psc;
    logic                      at_reload;

    assign at_reload = (psc == reload);
    assign enable    = en && at_reload;

    // clr has priority so a stop or restart always begins from a fresh phase.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            psc <= '0;
        end else if (clr) begin
            psc <= '0;
        end else if (en) begin
            psc <= at_reload ? '0 : psc + PSC_ONE;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// Programmable divide-by-N timer: config handshake, run/pause/stop FSM,
// terminal-count pulse and divided clock output.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int BIT_WIDTH      = 32,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [BIT_WIDTH-1:0]      cfg_target,
    input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
    input  logic                      cfg_periodic,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      resume,
    output logic                      tick_out,
    output logic                      clk_out,
    output logic [BIT_WIDTH-1:0]      cnt_out,
    output logic                      busy,
    output logic                      done,
    output logic [STATE_W-1:0]        state_out
);

    localparam logic [BIT_WIDTH-1:0] CNT_ONE = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state, state_nxt;
    logic [BIT_WIDTH-1:0]      target_q;
    logic [PRESCALE_WIDTH-1:0] prescale_q;
    logic                      periodic_q;
    logic                      cfg_loaded;
    logic [BIT_WIDTH-1:0]      cnt_nxt;
    logic                      tick_nxt;
    logic                      clk_nxt;
    logic                      cfg_accept;
    logic                      start_ok;
    logic                      start_take;
    logic                      psc_en;
    logic                      psc_clr;
    logic                      psc_enable;

    // Handshake: a config transfers on a cycle where cfg_valid and cfg_ready are both high.
    assign cfg_accept = cfg_valid && cfg_ready;
    // A same-cycle config counts as loaded, so start picks up the new values.
    assign start_ok   = start && (cfg_loaded || cfg_accept);
    assign start_take = !stop && ((state == IDLE) || (state == DONE)) && start_ok;
    assign psc_en     = (state == RUN) && !stop && !pause;
    assign psc_clr    = stop || start_take;
    assign state_out  = state;

    tick_prescaler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_prescaler (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .clr    (psc_clr),
        .en     (psc_en),
        .reload (prescale_q),
        .enable (psc_enable)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_out;
        tick_nxt  = 1'b0;
        clk_nxt   = clk_out;
        if (stop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            clk_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSE;
                    end else if (psc_enable) begin
                        if (cnt_out < target_q) begin
                            cnt_nxt = cnt_out + CNT_ONE;
                        end else begin
                            cnt_nxt  = '0;
                            tick_nxt = 1'b1;
                            clk_nxt  = ~clk_out;
                            if (!periodic_q) state_nxt = DONE;
                        end
                    end
                end
                PAUSE: begin
                    if (resume && !pause) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Status flags are decoded from the next state so they line up with state_out.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt_out    <= '0;
            tick_out   <= 1'b0;
            clk_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_ready  <= 1'b1;
            target_q   <= '0;
            prescale_q <= '0;
            periodic_q <= 1'b0;
            cfg_loaded <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_out   <= cnt_nxt;
            tick_out  <= tick_nxt;
            clk_out   <= clk_nxt;
            busy      <= (state_nxt == RUN) || (state_nxt == PAUSE);
            done      <= (state_nxt == DONE);
            cfg_ready <= (state_nxt == IDLE) || (state_nxt == DONE);
            if (cfg_accept) begin
                target_q   <= cfg_target;
                prescale_q <= cfg_prescale;
                periodic_q <= cfg_periodic;
                cfg_loaded <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: elapsed-time reference model checked every cycle,
// plus hand-computed latencies and levels for each scenario.
module tb_timer_ctrl;

    localparam logic [3:0] C_START  = 4'b1000;
    localparam logic [3:0] C_STOP   = 4'b0100;
    localparam logic [3:0] C_PAUSE  = 4'b0010;
    localparam logic [3:0] C_RESUME = 4'b0001;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_target;
    logic [15:0] cfg_prescale;
    logic        cfg_periodic;
    logic        start, stop, pause, resume;
    logic        tick_out, clk_out, busy, done;
    logic [31:0] cnt_out;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int start_edge = 0;
    bit mon_en = 1'b0;

    // Reference model: progress is tracked as elapsed RUN cycles within one period.
    int          m_state = 0;
    logic [63:0] m_el = '0, m_t = '0, m_p = '0;
    bit          m_per = 1'b0, m_loaded = 1'b0, m_tick = 1'b0, m_clk = 1'b0;

    timer_ctrl #(.BIT_WIDTH(32), .PRESCALE_WIDTH(16)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_target  (cfg_target),
        .cfg_prescale(cfg_prescale),
        .cfg_periodic(cfg_periodic),
        .start       (start),
        .stop        (stop),
        .pause       (pause),
        .resume      (resume),
        .tick_out    (tick_out),
        .clk_out     (clk_out),
        .cnt_out     (cnt_out),
        .busy        (busy),
        .done        (done),
        .state_out   (state_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin : model
        bit          acc;
        logic [63:0] period;
        if (!reset_n) begin
            m_state = 0; m_el = '0; m_tick = 1'b0; m_clk = 1'b0;
            m_loaded = 1'b0; m_t = '0; m_p = '0; m_per = 1'b0;
        end else begin
            acc    = cfg_valid && (m_state == 0 || m_state == 3);
            m_tick = 1'b0;
            if (acc) begin
                m_t = {32'd0, cfg_target}; m_p = {48'd0, cfg_prescale};
                m_per = cfg_periodic; m_loaded = 1'b1;
            end
            period = (m_t + 64'd1) * (m_p + 64'd1);
            if (stop) begin
                m_state = 0; m_el = '0; m_clk = 1'b0;
            end else if (m_state == 0 || m_state == 3) begin
                if (start && m_loaded) begin m_state = 1; m_el = '0; end
            end else if (m_state == 1) begin
                if (pause) m_state = 2;
                else begin
                    m_el = m_el + 64'd1;
                    if (m_el == period) begin
                        m_el = '0; m_tick = 1'b1; m_clk = !m_clk;
                        if (!m_per) m_state = 3;
                    end
                end
            end else if (resume && !pause) begin
                m_state = 1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (mon_en) begin
            check("mdl_state", state_out, m_state);
            check("mdl_cnt", cnt_out, m_el / (m_p + 64'd1));
            check("mdl_tick", tick_out, m_tick);
            check("mdl_clk", clk_out, m_clk);
            check("mdl_busy", busy, (m_state == 1 || m_state == 2));
            check("mdl_done", done, (m_state == 3));
            check("mdl_ready", cfg_ready, (m_state == 0 || m_state == 3));
        end
    end

    // All driver tasks are entered and left on a falling edge.
    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
    endtask

    task automatic send_cfg(input logic [31:0] t, input logic [15:0] p, input logic per);
        cfg_valid = 1'b1; cfg_target = t; cfg_prescale = p; cfg_periodic = per;
        @(negedge clk_in);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_cmd(input logic [3:0] c);
        {start, stop, pause, resume} = c;
        if (c[3]) start_edge = cyc + 1;
        @(negedge clk_in);
        {start, stop, pause, resume} = 4'b0000;
    endtask

    task automatic wait_tick(input int budget, output int edge_no);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (tick_out !== 1'b1 && n < budget);
        check("tick_seen", tick_out, 1'b1);
        edge_no = cyc;
    endtask

    task automatic wait_cnt(input logic [31:0] v, input int budget);
        int n = 0;
        while (cnt_out !== v && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check("cnt_reached", cnt_out, v);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stimulus
        int e1, e2;
        reset_n = 1'b0; cfg_valid = 1'b0; cfg_target = '0; cfg_prescale = '0;
        cfg_periodic = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; resume = 1'b0;
        repeat (2) @(negedge clk_in);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        check("rst_state", state_out, 0);
        check("rst_cnt", cnt_out, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_clk", clk_out, 0);

        // One-shot, target 3, no prescale.
        send_cfg(32'd3, 16'd0, 1'b0);
        pulse_cmd(C_START);
        wait_tick(50, e1);
        check("os_latency", e1 - start_edge, 4);
        check("os_clk", clk_out, 1);
        check("os_done", done, 1);
        check("os_cnt", cnt_out, 0);
        check("os_ready", cfg_ready, 1);

        // Periodic, target 1, prescale 2: tick every 6, clk_out period 12.
        send_cfg(32'd1, 16'd2, 1'b1);
        pulse_cmd(C_START);
        wait_tick(50, e1);
        check("per_first", e1 - start_edge, 6);
        check("per_clk0", clk_out, 0);
        wait_tick(50, e2);
        check("per_interval", e2 - e1, 6);
        check("per_clk1", clk_out, 1);
        check("per_busy", busy, 1);
        repeat (8) @(negedge clk_in);
        pulse_cmd(C_STOP);

        // Pause at cnt 5 for 7 cycles delays the tick from 10 to 17.
        send_cfg(32'd9, 16'd0, 1'b0);
        pulse_cmd(C_START);
        wait_cnt(32'd5, 50);
        pulse_cmd(C_PAUSE);
        for (int i = 0; i < 5; i++) begin
            check("pause_cnt", cnt_out, 5);
            check("pause_state", state_out, 2);
            @(negedge clk_in);
        end
        pulse_cmd(C_RESUME);
        wait_tick(50, e1);
        check("pause_latency", e1 - start_edge, 17);

        // Stop in the terminal cycle suppresses the tick and clears clk_out.
        send_cfg(32'd2, 16'd0, 1'b1);
        pulse_cmd(C_START);
        wait_cnt(32'd2, 50);
        check("stop_pre_clk", clk_out, 1);
        pulse_cmd(C_STOP);
        check("stop_tick", tick_out, 0);
        check("stop_state", state_out, 0);
        check("stop_cnt", cnt_out, 0);
        check("stop_clk", clk_out, 0);

        // Pause with terminal and resume in one cycle: pause wins, count holds at target.
        pulse_cmd(C_START);
        wait_cnt(32'd2, 50);
        pulse_cmd(C_PAUSE | C_RESUME);
        check("pr_state", state_out, 2);
        check("pr_cnt", cnt_out, 2);
        check("pr_tick", tick_out, 0);
        pulse_cmd(C_RESUME);
        check("pr_resumed", state_out, 1);
        @(negedge clk_in);
        check("pr_tick_after", tick_out, 1);
        pulse_cmd(C_STOP);

        // Config offered during RUN is dropped; re-offered in DONE it takes effect.
        send_cfg(32'd2, 16'd0, 1'b0);
        pulse_cmd(C_START);
        wait_cnt(32'd1, 50);
        check("run_ready", cfg_ready, 0);
        send_cfg(32'd5, 16'd0, 1'b0);
        wait_tick(50, e1);
        check("old_target_latency", e1 - start_edge, 3);
        check("done_ready", cfg_ready, 1);
        send_cfg(32'd5, 16'd0, 1'b0);
        pulse_cmd(C_START);
        wait_tick(50, e1);
        check("new_target_latency", e1 - start_edge, 6);

        // Start without a config, then reset in the middle of a run.
        do_reset();
        pulse_cmd(C_START);
        @(negedge clk_in);
        check("nocfg_state", state_out, 0);
        send_cfg(32'd1, 16'd0, 1'b1);
        pulse_cmd(C_START);
        wait_tick(50, e1);
        check("midrst_pre_clk", clk_out, 1);
        reset_n = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        check("midrst_state", state_out, 0);
        check("midrst_cnt", cnt_out, 0);
        check("midrst_clk", clk_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ready", cfg_ready, 1);
        pulse_cmd(C_START);
        @(negedge clk_in);
        check("midrst_unloaded", state_out, 0);

        // Widest target counts up without wrapping.
        send_cfg(32'hFFFF_FFFF, 16'd0, 1'b1);
        pulse_cmd(C_START);
        repeat (10) @(negedge clk_in);
        check("max_cnt", cnt_out, 10);
        pulse_cmd(C_STOP);

        // Target 0 with prescale 1: terminal on every enable.
        send_cfg(32'd0, 16'd1, 1'b1);
        pulse_cmd(C_START);
        wait_tick(20, e1);
        check("t0_first", e1 - start_edge, 2);
        wait_tick(20, e2);
        check("t0_interval", e2 - e1, 2);
        pulse_cmd(C_STOP);
        repeat (3) @(negedge clk_in);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
